// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 8N1 serial receiver with oversampled majority voting
// and a single-entry valid/ready output buffer.
module uart_rx_oversampled #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_en,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);
    // state   | meaning
    // S_IDLE  | line idle, waiting for a low synced line
    // S_START | start bit, re-checked at mid-bit
    // S_DATA  | one voted sample per bit period, LSB first
    // S_STOP  | stop bit sampled at mid-bit
    // S_BREAK | stop bit was low, waiting for the line to go high

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 sync1;
    logic                 sync2;
    logic [2:0]           samp;
    logic                 voted_q;
    logic [TW-1:0]        tick;
    logic [TW-1:0]        tick_nxt;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic                 shift_en;
    logic                 frame_done;
    logic                 stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            samp    <= 3'b111;
            voted_q <= 1'b1;
        end else begin
            sync1 <= rx_pin;
            sync2 <= sync1;
            if (sample_en) begin
                samp    <= {samp[1:0], sync2};
                voted_q <= (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            tick    <= tick_nxt;
            bit_cnt <= bit_nxt;
            if (shift_en) begin
                shreg <= {voted_q, shreg[DATA_BITS-1:1]};
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        tick_nxt   = tick;
        bit_nxt    = bit_cnt;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        stop_bad   = 1'b0;
        if (sample_en) begin
            case (state)
                S_IDLE: begin
                    if (!sync2) begin
                        state_nxt = S_START;
                        tick_nxt  = '0;
                    end
                end
                S_START: begin
                    if (tick == TICK_MID) begin
                        tick_nxt = '0;
                        bit_nxt  = '0;
                        state_nxt = voted_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_nxt = tick + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick == TICK_END) begin
                        tick_nxt = '0;
                        shift_en = 1'b1;
                        bit_nxt  = bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = S_STOP;
                        end
                    end else begin
                        tick_nxt = tick + TW'(1);
                    end
                end
                S_STOP: begin
                    if (tick == TICK_END) begin
                        tick_nxt = '0;
                        if (voted_q) begin
                            frame_done = 1'b1;
                            state_nxt  = S_IDLE;
                        end else begin
                            stop_bad  = 1'b1;
                            state_nxt = S_BREAK;
                        end
                    end else begin
                        tick_nxt = tick + TW'(1);
                    end
                end
                S_BREAK: begin
                    if (voted_q) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // A completing frame wins over a same-cycle drain, so rx_valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: directed and randomized 8N1 frames checked
// against a frame-level model of what the consumer should receive.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;
    localparam int OS  = 16;
    localparam int DW  = 8;
    localparam int NOM = 1600; // clk per bit, x100

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_en;
    logic          rx_pin;
    logic          rx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;

    int  tests = 0;
    int  fails = 0;
    bit  half_rate = 1'b0;
    bit  gate_off = 1'b0;
    bit  rand_ready = 1'b0;
    int  ready_pct = 50;

    logic [DW-1:0] got[$];
    int            err_total = 0;
    int            ovr_total = 0;

    always #5 clk = ~clk;

    uart_rx_oversampled #(.OVERSAMPLE(OS), .DATA_BITS(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .rx_pin    (rx_pin),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) err_total++;
            if (overrun) ovr_total++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        sample_en = gate_off ? 1'b0 : (half_rate ? ~sample_en : 1'b1);
        if (rand_ready) rx_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [DW-1:0] b, input bit stop_bit, input int per);
        int idx;
        for (int c = 0; c * 100 < 10 * per; c++) begin
            idx = (c * 100) / per;
            if (idx == 0) rx_pin = 1'b0;
            else if (idx <= DW) rx_pin = b[idx-1];
            else rx_pin = stop_bit;
            step();
        end
        rx_pin = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; sample_en = 1'b1; rx_pin = 1'b1; rx_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_latency();
        int cnt = 0;
        int base = got.size();
        int e0 = err_total;
        rx_ready = 1'b0;
        fork
            send_frame(8'h54, 1'b1, NOM);
            begin
                while (rx_valid !== 1'b1 && cnt < 400) begin
                    @(posedge clk); #1; cnt++;
                end
            end
        join
        tests++; if (cnt < 155 || cnt > 159) begin fails++; $display("FAIL latency: got %0d cycles expected 155..159", cnt); end
        tests++; if (rx_data !== 8'h54) begin fails++; $display("FAIL latency_data: got %h expected 54", rx_data); end
        tests++; if (err_total != e0) begin fails++; $display("FAIL latency_frame_err: got %0d pulses expected 0", err_total - e0); end
        rx_ready = 1'b1; step(); rx_ready = 1'b0; idle(2);
        tests++; if (got.size() != base + 1 || got[base] !== 8'h54) begin fails++; $display("FAIL latency_accept: got %0d bytes expected 1 byte 54", got.size() - base); end
    endtask

    task automatic test_glitch();
        int base = got.size();
        int e0 = err_total;
        rx_ready = 1'b1;
        rx_pin = 1'b0; idle(4); rx_pin = 1'b1; idle(40);
        tests++; if (got.size() != base || err_total != e0) begin fails++; $display("FAIL glitch_start: got %0d bytes %0d errs expected 0 0", got.size() - base, err_total - e0); end
        for (int c = 0; c < 10 * OS; c++) begin
            rx_pin = (c >= 9 * OS) ? 1'b1 : 1'b0;
            if (c == 4 * OS + OS / 2) rx_pin = 1'b1;
            step();
        end
        rx_pin = 1'b1; idle(20);
        tests++; if (got.size() != base + 1 || got[base] !== 8'h00) begin fails++; $display("FAIL glitch_spike: got %0d bytes expected 1 byte 00", got.size() - base); end
        tests++; if (err_total != e0) begin fails++; $display("FAIL glitch_err: got %0d errs expected 0", err_total - e0); end
    endtask

    task automatic test_framing();
        int base = got.size();
        int e0 = err_total;
        rx_ready = 1'b0;
        send_frame(8'hA5, 1'b0, NOM);
        rx_pin = 1'b0; idle(40);
        tests++; if (err_total - e0 != 1) begin fails++; $display("FAIL framing_err: got %0d pulses expected 1", err_total - e0); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL framing_valid: got %b expected 0", rx_valid); end
        rx_pin = 1'b1; idle(48);
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b1, NOM);
        idle(20);
        tests++; if (got.size() != base + 1 || got[base] !== 8'h3C) begin fails++; $display("FAIL framing_recover: got %0d bytes expected 1 byte 3C", got.size() - base); end
        tests++; if (err_total - e0 != 1) begin fails++; $display("FAIL framing_err_total: got %0d pulses expected 1", err_total - e0); end
    endtask

    task automatic test_backpressure();
        int base = got.size();
        int o0 = ovr_total;
        int bad = 0;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, NOM);
        fork
            send_frame(8'h22, 1'b1, NOM);
            begin
                repeat (150) begin
                    @(negedge clk);
                    if (rx_data !== 8'h11 || rx_valid !== 1'b1) bad++;
                end
            end
        join
        idle(4);
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold: got %0d changed cycles expected 0", bad); end
        tests++; if (rx_data !== 8'h11) begin fails++; $display("FAIL bp_data: got %h expected 11", rx_data); end
        tests++; if (ovr_total - o0 != 1) begin fails++; $display("FAIL bp_overrun: got %0d pulses expected 1", ovr_total - o0); end
        fork
            send_frame(8'h33, 1'b1, NOM);
            begin
                repeat (154) @(posedge clk);
                #2 rx_ready = 1'b1;
            end
        join
        idle(10);
        tests++; if (got.size() != base + 2) begin fails++; $display("FAIL bp_count: got %0d bytes expected 2", got.size() - base); end
        else begin
            tests++; if (got[base] !== 8'h11 || got[base+1] !== 8'h33) begin fails++; $display("FAIL bp_order: got %h %h expected 11 33", got[base], got[base+1]); end
        end
        tests++; if (ovr_total - o0 != 1) begin fails++; $display("FAIL bp_overrun_final: got %0d pulses expected 1", ovr_total - o0); end
    endtask

    task automatic test_reset_mid();
        int base;
        logic [DW-1:0] b = 8'h99;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, NOM);
        idle(4);
        for (int c = 0; c < 5 * OS + OS / 2; c++) begin
            rx_pin = (c < OS) ? 1'b0 : b[c/OS-1];
            step();
        end
        rst_n = 1'b0;
        #1;
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b expected 0", rx_valid); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
        tests++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL rstmid_pulses: got %b%b expected 00", frame_err, overrun); end
        rx_pin = 1'b1; idle(3);
        rst_n = 1'b1; idle(20);
        rx_ready = 1'b1;
        base = got.size();
        send_frame(8'h7E, 1'b1, NOM);
        idle(20);
        tests++; if (got.size() != base + 1 || got[base] !== 8'h7E) begin fails++; $display("FAIL rstmid_recover: got %0d bytes expected 1 byte 7E", got.size() - base); end
    endtask

    task automatic test_sample_en();
        int base = got.size();
        int e0 = err_total;
        rx_ready = 1'b1;
        gate_off = 1'b1;
        send_frame(8'hC3, 1'b1, NOM);
        idle(10);
        tests++; if (got.size() != base || err_total != e0) begin fails++; $display("FAIL gated: got %0d bytes %0d errs expected 0 0", got.size() - base, err_total - e0); end
        gate_off = 1'b0;
        half_rate = 1'b1;
        send_frame(8'h96, 1'b1, 2 * NOM);
        idle(80);
        half_rate = 1'b0;
        idle(2);
        tests++; if (got.size() != base + 1 || got[base] !== 8'h96) begin fails++; $display("FAIL half_rate: got %0d bytes expected 1 byte 96", got.size() - base); end
    endtask

    task automatic test_random();
        logic [DW-1:0] good_q[$];
        logic [DW-1:0] b;
        int nbad = 0;
        int base = got.size();
        int e0 = err_total;
        int o0 = ovr_total;
        int per;
        int j = 0;
        int n;
        bit bad;
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b = DW'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 2))
                0: per = 1552;
                1: per = 1600;
                default: per = 1648;
            endcase
            ready_pct = $urandom_range(0, 1) ? 60 : 1;
            send_frame(b, !bad, per);
            if (bad) begin
                nbad++;
                idle(48);
            end else begin
                good_q.push_back(b);
                idle($urandom_range(0, 30));
            end
        end
        rand_ready = 1'b0;
        rx_ready = 1'b1;
        idle(200);
        n = got.size() - base;
        tests++; if (err_total - e0 != nbad) begin fails++; $display("FAIL rand_frame_err: got %0d expected %0d", err_total - e0, nbad); end
        tests++; if (n + (ovr_total - o0) != good_q.size()) begin fails++; $display("FAIL rand_accounting: got %0d accepted + %0d overrun expected %0d frames", n, ovr_total - o0, good_q.size()); end
        for (int k = 0; k < n; k++) begin
            while (j < good_q.size() && good_q[j] !== got[base+k]) j++;
            tests++;
            if (j >= good_q.size()) begin fails++; $display("FAIL rand_order: got byte %h at %0d expected an in-order sent byte", got[base+k], k); end
            else j++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_framing();
        test_backpressure();
        test_reset_mid();
        test_sample_en();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
